// File: rtl/branch_target_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_target_predictor_if
// Groups the signals between the pipeline and the branch target predictor.
//   master : pipeline side. Drives the fetch PC, the EX-stage resolution
//            update and clear_req. Receives the prediction, ready and stats.
//   slave  : predictor side.
// Signals:
//   pc_if            fetch PC being looked up this cycle
//   predict_taken    predicted taken for pc_if
//   predict_target   predicted next PC for pc_if
//   ready            table swept, predictions enabled
//   upd_valid        EX resolved a control transfer this cycle
//   upd_pc           PC of the resolved instruction
//   upd_taken        actual direction, 1 = taken
//   upd_target       actual target when taken
//   upd_mispredict   the prediction was wrong (statistics only)
//   clear_req        invalidate the whole table
//   stat_branches    resolved control transfers counted
//   stat_mispredicts mispredictions counted
// ---------------------------------------------------------------------------
interface branch_target_predictor_if;
    logic [31:0] pc_if;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        ready;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        clear_req;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output pc_if, upd_valid, upd_pc, upd_taken, upd_target,
               upd_mispredict, clear_req,
        input  predict_taken, predict_target, ready,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  pc_if, upd_valid, upd_pc, upd_taken, upd_target,
               upd_mispredict, clear_req,
        output predict_taken, predict_target, ready,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_target_predictor.sv
// ---------------------------------------------------------------------------
// branch_target_predictor
// Direct-mapped table of 2-bit saturating counters with tags and targets.
// It gives the IF stage a zero-latency taken/target prediction for pc_if and
// learns from control transfers resolved in EX. After reset or clear_req, a
// sequencer sweeps the valid bits of every entry before it raises ready.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bp     branch_target_predictor_if.slave (lookup, update, clear, stats)
//
// Optional feature macro: BP_PERF_CNT_EN. When it is defined, the
// stat_branches and stat_mispredicts counters are built. When it is
// undefined, both outputs are tied to 0.
//
// Sequencer states:
//   state   | meaning
//   ST_INIT | sweeping valid bits, one entry per cycle; ready = 0
//   ST_RUN  | table usable; lookups and updates enabled; ready = 1
// ---------------------------------------------------------------------------
module branch_target_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    branch_target_predictor_if.slave   bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q;
    logic [INDEX_BITS-1:0]   ptr_q;
    logic                    ready_q;

    logic                    valid_q [ENTRIES];
    logic [TAG_BITS-1:0]     tag_q   [ENTRIES];
    logic [31:0]             tgt_q   [ENTRIES];
    logic [1:0]              ctr_q   [ENTRIES];

    // Sequencer. ready_q is registered and tracks state_q == ST_RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (bp.clear_req) begin
                        ptr_q <= '0;
                    end else if (&ptr_q) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bp.clear_req) begin
                        state_q <= ST_INIT;
                        ready_q <= 1'b0;
                        ptr_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    ready_q <= 1'b0;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    // Update path
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  up_hit;

    assign up_idx = bp.upd_pc[INDEX_BITS+1:2];
    assign up_tag = bp.upd_pc[TAG_HI:TAG_LO];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // The table is not reset. The sweep invalidates every entry before
    // ready rises, and every lookup is gated by ready.
    always_ff @(posedge clk) begin
        if (!ready_q) begin
            valid_q[ptr_q] <= 1'b0;
        end else if (bp.upd_valid) begin
            if (up_hit) begin
                if (bp.upd_taken) begin
                    if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'b01;
                    tgt_q[up_idx] <= bp.upd_target;
                end else begin
                    if (ctr_q[up_idx] != 2'b00) ctr_q[up_idx] <= ctr_q[up_idx] - 2'b01;
                end
            end else if (bp.upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                tgt_q[up_idx]   <= bp.upd_target;
                ctr_q[up_idx]   <= 2'b10;
            end
        end
    end

    // Lookup path. There is no bypass, so a same-cycle update is not visible.
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic                  lk_hit;
    logic                  lk_taken;

    assign lk_idx   = bp.pc_if[INDEX_BITS+1:2];
    assign lk_tag   = bp.pc_if[TAG_HI:TAG_LO];
    assign lk_hit   = ready_q && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_q[lk_idx][1];

    assign bp.predict_taken  = lk_taken;
    assign bp.predict_target = lk_taken ? tgt_q[lk_idx] : (bp.pc_if + 32'd4);
    assign bp.ready          = ready_q;

    // PC bits that take part in neither the index nor the tag
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pc_if[1:0],  bp.pc_if[31:TAG_HI+1],
                              bp.upd_pc[1:0], bp.upd_pc[31:TAG_HI+1]};

`ifdef BP_PERF_CNT_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    // Both counters wrap naturally. clear_req does not reset them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (bp.upd_valid && ready_q) begin
            stat_br_q <= stat_br_q + 32'd1;
            if (bp.upd_mispredict) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign bp.stat_branches    = stat_br_q;
    assign bp.stat_mispredicts = stat_mp_q;
`else
    logic unused_mispredict;
    assign unused_mispredict   = bp.upd_mispredict;
    assign bp.stat_branches    = 32'd0;
    assign bp.stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;
    logic clk;
    logic rst_n;

    branch_target_predictor_if bp ();

    branch_target_predictor #(.INDEX_BITS(6), .TAG_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the table as seen from the specification's rules
    bit          m_valid [64];
    int          m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    int          m_sweep_left;
    logic [31:0] m_br;
    logic [31:0] m_mp;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int tag_of(logic [31:0] pc);
        return int'((pc >> 8) % 256);
    endfunction

    function automatic bit m_ready();
        return (m_sweep_left == 0);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic logic m_taken(logic [31:0] pc);
        return m_ready() && m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(logic [31:0] pc);
        return m_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic logic [31:0] exp_br();
`ifdef BP_PERF_CNT_EN
        return m_br;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_mp();
`ifdef BP_PERF_CNT_EN
        return m_mp;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_sweep_left = 64;
        m_br = '0;
        m_mp = '0;
    endtask

    // Apply one clock edge to the model. It reads the inputs that the DUT sees at this edge.
    task automatic model_edge();
        int i;
        if (m_ready() && bp.upd_valid) begin
            m_br = m_br + 32'd1;
            if (bp.upd_mispredict) m_mp = m_mp + 32'd1;
            i = idx_of(bp.upd_pc);
            if (m_hit(bp.upd_pc)) begin
                if (bp.upd_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = bp.upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (bp.upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(bp.upd_pc);
                m_tgt[i]   = bp.upd_target;
                m_ctr[i]   = 2;
            end
        end
        if (bp.clear_req) begin
            for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
            m_sweep_left = 64;
        end else if (m_sweep_left > 0) begin
            m_sweep_left = m_sweep_left - 1;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic um,
                         input logic [31:0] pc, input logic clr);
        bp.upd_valid      = uv;
        bp.upd_pc         = upc;
        bp.upd_taken      = ut;
        bp.upd_target     = utgt;
        bp.upd_mispredict = um;
        bp.pc_if          = pc;
        bp.clear_req      = clr;
    endtask

    // One cycle. Outputs are sampled at the negedge, then the clock edge is
    // taken, and the caller drives new inputs 1 time unit after the edge.
    task automatic step(input bit use_exp, input logic et, input logic [31:0] etgt,
                        input string nm);
        @(negedge clk);
        check("ready",          {31'd0, bp.ready},         {31'd0, m_ready()});
        check("predict_taken",  {31'd0, bp.predict_taken}, {31'd0, m_taken(bp.pc_if)});
        check("predict_target", bp.predict_target,         m_target(bp.pc_if));
        check("stat_branches",    bp.stat_branches,    exp_br());
        check("stat_mispredicts", bp.stat_mispredicts, exp_mp());
        if (use_exp) begin
            check({nm, "_taken"},  {31'd0, bp.predict_taken}, {31'd0, et});
            check({nm, "_target"}, bp.predict_target,         etgt);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 32'h100, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        um;
        logic [31:0] pc;
        logic        et;
        logic [31:0] etgt;
    } vec_t;

    vec_t vecs [17];

    logic [31:0] pool [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected values worked out by hand from the counter and allocation rules
        vecs[0]  = '{1'b1, 32'h200,  1'b1, 32'h80,   1'b0, 32'h200,  1'b0, 32'h204};  // same-cycle collision
        vecs[1]  = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h200,  1'b1, 32'h80};
        vecs[2]  = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h1200, 1'b0, 32'h1204}; // alias index, other tag
        vecs[3]  = '{1'b1, 32'h200,  1'b1, 32'h80,   1'b1, 32'h200,  1'b1, 32'h80};   // ctr 2->3
        vecs[4]  = '{1'b1, 32'h200,  1'b1, 32'h80,   1'b0, 32'h200,  1'b1, 32'h80};   // sat 3
        vecs[5]  = '{1'b1, 32'h200,  1'b1, 32'h80,   1'b0, 32'h200,  1'b1, 32'h80};   // sat 3
        vecs[6]  = '{1'b1, 32'h200,  1'b0, 32'h0,    1'b1, 32'h200,  1'b1, 32'h80};   // 3->2
        vecs[7]  = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h200,  1'b1, 32'h80};
        vecs[8]  = '{1'b1, 32'h200,  1'b0, 32'h0,    1'b0, 32'h200,  1'b1, 32'h80};   // 2->1
        vecs[9]  = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h200,  1'b0, 32'h204};
        vecs[10] = '{1'b1, 32'h1200, 1'b1, 32'h3000, 1'b1, 32'h200,  1'b0, 32'h204};  // overwrite entry
        vecs[11] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h1200, 1'b1, 32'h3000};
        vecs[12] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h200,  1'b0, 32'h204};
        vecs[13] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0}; // wrap
        vecs[14] = '{1'b1, 32'h1200, 1'b1, 32'h4000, 1'b0, 32'h1200, 1'b1, 32'h3000}; // pre-update target
        vecs[15] = '{1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h1200, 1'b1, 32'h4000};
        vecs[16] = '{1'b1, 32'h1200, 1'b0, 32'h0,    1'b0, 32'h1200, 1'b1, 32'h4000}; // 3->2 no target change

        pool[0] = 32'h200;  pool[1] = 32'h1200; pool[2] = 32'h204;  pool[3] = 32'h2204;
        pool[4] = 32'h300;  pool[5] = 32'h1000_0200; pool[6] = 32'hFFFF_FFFC; pool[7] = 32'h3FC;

        // Reset release. ready stays low for 64 cycles and predictions fall through to pc + 4.
        apply_reset();
        for (int c = 0; c < 64; c++) step(1, 1'b0, 32'h104, "reset_fallthrough");
        @(negedge clk);
        check("ready_after_64", {31'd0, bp.ready}, 32'd1);
        @(posedge clk); model_edge(); #1;

        // Reset in the middle of the sweep restarts it from the beginning
        apply_reset();
        for (int c = 0; c < 20; c++) step(0, 1'b0, 32'h0, "");
        apply_reset();
        for (int c = 0; c < 64; c++) step(1, 1'b0, 32'h104, "midsweep_reset");
        step(0, 1'b0, 32'h0, "");

        // Directed vector table
        for (int v = 0; v < 17; v++) begin
            drive(vecs[v].uv, vecs[v].upc, vecs[v].ut, vecs[v].utgt, vecs[v].um, vecs[v].pc, 1'b0);
            step(1, vecs[v].et, vecs[v].etgt, $sformatf("vec%0d", v));
        end

        // Train the entry, clear the table, and drive updates during the sweep. They must be ignored.
        drive(1, 32'h200, 1, 32'h80, 0, 32'h200, 0);
        step(0, 1'b0, 32'h0, "");
        step(1, 1'b1, 32'h80, "trained");
        drive(0, 32'h0, 0, 32'h0, 0, 32'h200, 1);
        step(1, 1'b1, 32'h80, "clear_cycle");
        drive(1, 32'h200, 1, 32'h80, 1, 32'h200, 0);
        for (int c = 0; c < 64; c++) step(1, 1'b0, 32'h204, "during_clear");
        drive(0, 32'h0, 0, 32'h0, 0, 32'h200, 0);
        @(negedge clk);
        check("ready_after_clear", {31'd0, bp.ready}, 32'd1);
        check("after_clear_taken", {31'd0, bp.predict_taken}, 32'd0);
        @(posedge clk); model_edge(); #1;

        // Clear requested again while a sweep is already running
        drive(0, 32'h0, 0, 32'h0, 0, 32'h200, 1);
        step(0, 1'b0, 32'h0, "");
        drive(0, 32'h0, 0, 32'h0, 0, 32'h200, 0);
        for (int c = 0; c < 10; c++) step(0, 1'b0, 32'h0, "");
        drive(0, 32'h0, 0, 32'h0, 0, 32'h200, 1);
        step(0, 1'b0, 32'h0, "");
        drive(0, 32'h0, 0, 32'h0, 0, 32'h200, 0);
        for (int c = 0; c < 64; c++) step(1, 1'b0, 32'h204, "reclear");
        step(0, 1'b0, 32'h0, "");

        // Random traffic checked against the model
        for (int c = 0; c < 2500; c++) begin
            drive($urandom_range(0, 1) == 1,
                  pool[$urandom_range(0, 7)],
                  $urandom_range(0, 9) < 6,
                  $urandom() & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) == 0,
                  pool[$urandom_range(0, 7)],
                  $urandom_range(0, 299) == 0);
            step(0, 1'b0, 32'h0, "");
        end

        // Statistics: 10 accepted updates, 3 of them flagged mispredict
        apply_reset();
        for (int c = 0; c < 64; c++) step(0, 1'b0, 32'h0, "");
        for (int c = 0; c < 10; c++) begin
            drive(1, 32'h400 + 32'(c * 4), c[0], 32'h800, c < 3, 32'h100, 0);
            step(0, 1'b0, 32'h0, "");
        end
        drive(0, 32'h0, 0, 32'h0, 0, 32'h100, 0);
        @(negedge clk);
`ifdef BP_PERF_CNT_EN
        check("stat_branches_10",   bp.stat_branches,    32'd10);
        check("stat_mispredicts_3", bp.stat_mispredicts, 32'd3);
`else
        check("stat_branches_off",    bp.stat_branches,    32'd0);
        check("stat_mispredicts_off", bp.stat_mispredicts, 32'd0);
`endif
        // The counters are not affected by clear_req
        @(posedge clk); model_edge(); #1;
        drive(0, 32'h0, 0, 32'h0, 0, 32'h100, 1);
        step(0, 1'b0, 32'h0, "");
        drive(0, 32'h0, 0, 32'h0, 0, 32'h100, 0);
        step(0, 1'b0, 32'h0, "");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
